// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and register-match helper for the hazard stall controller
package hazard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hz_state_t;

    localparam logic [1:0] STALL_LOAD_USE = 2'd1;
    localparam logic [1:0] STALL_BR_LOAD  = 2'd2;
    localparam logic [4:0] REG_ZERO       = 5'd0;

    // True when the ID instruction actually reads register r; $0 never creates a dependency.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return (r != REG_ZERO) && ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline-side signal bundle of the hazard stall controller
interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_ID_rs;
    logic [4:0]       IF_ID_rt;
    logic             ID_uses_rs;
    logic             ID_uses_rt;
    logic             ID_is_branch;
    logic             ID_EX_mem_read;
    logic [4:0]       ID_EX_rd;
    logic             EX_MEM_mem_read;
    logic [4:0]       EX_MEM_rd;
    logic             branch_taken;
    logic             dmem_busy;
    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Pipeline side: presents instruction/hazard info, consumes the control enables.
    modport master (
        output IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt, ID_is_branch,
               ID_EX_mem_read, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd,
               branch_taken, dmem_busy,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold,
               mem_timeout, stall_cycles, flush_count
    );

    // Controller side.
    modport slave (
        input  IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt, ID_is_branch,
               ID_EX_mem_read, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd,
               branch_taken, dmem_busy,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold,
               mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - saturating event counter with asynchronous reset
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / branch-on-load stall sequencer with memory freeze and watchdog
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_stall_controller_if.slave bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    hz_state_t       state;
    hz_state_t       state_next;
    logic [1:0]      remain;
    logic [1:0]      remain_next;
    logic [WD_W-1:0] wd_cnt;
    logic            mem_timeout_q;
    logic            haz_a;
    logic            haz_b;
    logic [1:0]      need;
    logic            freeze;
    logic            stall;

    // Hazards forwarding cannot cover: load result needed in ID one or two stages too early.
    always_comb begin
        haz_a = bus.ID_EX_mem_read &&
                reg_match(bus.ID_EX_rd, bus.IF_ID_rs, bus.IF_ID_rt, bus.ID_uses_rs, bus.ID_uses_rt);
        haz_b = bus.ID_is_branch && bus.EX_MEM_mem_read &&
                reg_match(bus.EX_MEM_rd, bus.IF_ID_rs, bus.IF_ID_rt, bus.ID_uses_rs, bus.ID_uses_rt);
        // A branch compares in ID, so a load still in EX costs it two bubbles.
        need  = (haz_a && bus.ID_is_branch) ? STALL_BR_LOAD : STALL_LOAD_USE;
    end

    // Next state and stall decision; freeze wins and holds everything.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        stall       = 1'b0;
        freeze      = bus.dmem_busy;
        if (!freeze) begin
            case (state)
                RUN: begin
                    if (haz_a || haz_b) begin
                        stall = 1'b1;
                        if (need == STALL_BR_LOAD) begin
                            state_next  = HOLD;
                            remain_next = need - 2'd1;
                        end
                    end
                end
                HOLD: begin
                    stall = 1'b1;
                    if (remain <= 2'd1) begin
                        remain_next = 2'd0;
                        state_next  = RUN;
                    end else begin
                        remain_next = remain - 2'd1;
                    end
                end
                default: begin
                    state_next  = RUN;
                    remain_next = 2'd0;
                end
            endcase
        end
    end

    // Pipeline enables; reset forces a frozen, non-advancing pipe without waiting for a clock.
    always_comb begin
        bus.pc_write     = !rst && !freeze && !stall;
        bus.IF_ID_write  = !rst && !freeze && !stall;
        bus.ID_EX_bubble = !rst && stall;
        bus.IF_ID_flush  = !rst && bus.branch_taken && !stall && !freeze;
        bus.pipe_hold    = rst || freeze;
        bus.mem_timeout  = mem_timeout_q;
    end

    // Stall FSM state and remaining HOLD cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            remain <= 2'd0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
        end
    end

    // Watchdog on consecutive busy cycles; the error flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt        <= '0;
            mem_timeout_q <= 1'b0;
        end else if (bus.dmem_busy) begin
            if (wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                mem_timeout_q <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.ID_EX_bubble),
        .count (bus.stall_cycles)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.IF_ID_flush),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed table and sequence bench for hazard_stall_controller
module tb_hazard_stall_controller;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       exr;
        logic [4:0] exrd;
        logic       memr;
        logic [4:0] memrd;
        logic       taken;
        logic       busy;
        logic       pcw;
        logic       bub;
        logic       fl;
        logic       hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(
        input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
        input logic br, input logic exr, input logic [4:0] exrd, input logic memr,
        input logic [4:0] memrd, input logic taken, input logic busy,
        input logic pcw, input logic bub, input logic fl, input logic hold
    );
        vec_t v;
        v = '{rs, rt, urs, urt, br, exr, exrd, memr, memrd, taken, busy, pcw, bub, fl, hold};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input vec_t v);
        bus.IF_ID_rs        = v.rs;
        bus.IF_ID_rt        = v.rt;
        bus.ID_uses_rs      = v.urs;
        bus.ID_uses_rt      = v.urt;
        bus.ID_is_branch    = v.br;
        bus.ID_EX_mem_read  = v.exr;
        bus.ID_EX_rd        = v.exrd;
        bus.EX_MEM_mem_read = v.memr;
        bus.EX_MEM_rd       = v.memrd;
        bus.branch_taken    = v.taken;
        bus.dmem_busy       = v.busy;
    endtask

    task automatic set_idle();
        vec_t z;
        z = '0;
        drive(z);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic pcw, input logic bub, input logic fl, input logic hold);
        chk({tag, "/pc_write"},     bus.pc_write,     pcw);
        chk({tag, "/IF_ID_write"},  bus.IF_ID_write,  pcw);
        chk({tag, "/ID_EX_bubble"}, bus.ID_EX_bubble, bub);
        chk({tag, "/IF_ID_flush"},  bus.IF_ID_flush,  fl);
        chk({tag, "/pipe_hold"},    bus.pipe_hold,    hold);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // rs, rt, urs, urt, br, exr, exrd, memr, memrd, taken, busy | pcw, bub, fl, hold
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[1]  = mk(2, 5, 1, 1, 0, 1, 2, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[2]  = mk(4, 7, 1, 1, 0, 1, 7, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[3]  = mk(4, 7, 1, 0, 0, 1, 7, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[5]  = mk(2, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0,  1, 0, 0, 0);
        vecs[6]  = mk(1, 3, 1, 1, 1, 0, 0, 1, 3, 0, 0,  0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0);
        vecs[8]  = mk(1, 3, 1, 1, 0, 0, 0, 1, 3, 0, 0,  1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0);
        vecs[10] = mk(2, 0, 1, 0, 1, 1, 2, 0, 0, 1, 0,  0, 1, 0, 0);
        vecs[11] = mk(2, 0, 1, 0, 0, 1, 2, 0, 0, 1, 1,  0, 0, 0, 1);
        vecs[12] = mk(0, 9, 0, 1, 1, 1, 9, 0, 0, 0, 0,  0, 1, 0, 0);

        // Reset values while rst is held, even with a hazard and taken branch presented.
        rst = 1'b1;
        drive(vecs[10]);
        @(negedge clk);
        chk_outs("reset", 0, 0, 0, 1);
        chk("reset/stall_cycles", bus.stall_cycles, 0);
        chk("reset/flush_count",  bus.flush_count,  0);
        chk("reset/mem_timeout",  bus.mem_timeout,  0);
        set_idle();
        rst = 1'b0;

        // Single-cycle decisions from RUN; inputs return to idle before each edge.
        for (int i = 0; i < 13; i++) begin
            tick();
            drive(vecs[i]);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].pcw, vecs[i].bub, vecs[i].fl, vecs[i].hold);
            set_idle();
        end

        // lw $2 in EX, add uses $2: one bubble.
        do_reset();
        drive(mk(2, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("lu_c1", 0, 1, 0, 0);
        tick();
        drive(mk(2, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("lu_c2", 1, 0, 0, 0);
        tick();
        chk("lu/stall_cycles", bus.stall_cycles, 1);

        // lw $2 in EX, beq uses $2: two bubbles, second comes from HOLD with detection masked.
        do_reset();
        drive(mk(2, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("bl_c1", 0, 1, 0, 0);
        tick();
        set_idle();
        @(negedge clk); chk_outs("bl_hold", 0, 1, 0, 0);
        tick();
        @(negedge clk); chk_outs("bl_c3", 1, 0, 0, 0);
        tick();
        chk("bl/stall_cycles", bus.stall_cycles, 2);

        // lw $3 in MEM, beq uses rt=$3: one bubble.
        do_reset();
        drive(mk(1, 3, 1, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("hb_c1", 0, 1, 0, 0);
        tick();
        set_idle();
        @(negedge clk); chk_outs("hb_c2", 1, 0, 0, 0);
        tick();
        chk("hb/stall_cycles", bus.stall_cycles, 1);

        // Taken branch flushes; a stalled taken branch waits for the first unstalled cycle.
        do_reset();
        drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("fl_c1", 1, 0, 1, 0);
        tick();
        set_idle();
        @(negedge clk); chk_outs("fl_c2", 1, 0, 0, 0);
        tick();
        chk("fl/flush_count", bus.flush_count, 1);
        drive(mk(2, 0, 1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("flh_c1", 0, 1, 0, 0);
        tick();
        drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("flh_c2", 1, 0, 1, 0);
        tick();
        set_idle();
        chk("flh/flush_count",  bus.flush_count,  2);
        chk("flh/stall_cycles", bus.stall_cycles, 1);

        // Freeze for 3 cycles while in HOLD: remaining bubble is preserved.
        do_reset();
        drive(mk(2, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("fz_c1", 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            @(negedge clk); chk_outs($sformatf("fz_busy%0d", i), 0, 0, 0, 1);
            tick();
        end
        chk("fz/stall_cycles", bus.stall_cycles, 1);
        chk("fz/mem_timeout",  bus.mem_timeout,  0);
        set_idle();
        @(negedge clk); chk_outs("fz_resume", 0, 1, 0, 0);
        tick();
        @(negedge clk); chk_outs("fz_done", 1, 0, 0, 0);
        tick();
        chk("fz/stall_cycles_end", bus.stall_cycles, 2);

        // Watchdog: 3 busy cycles is short of the limit, the 4th sets the sticky error.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tick();
        chk("wd/before_limit", bus.mem_timeout, 0);
        tick();
        chk("wd/at_limit", bus.mem_timeout, 1);
        set_idle();
        tick();
        chk("wd/sticky", bus.mem_timeout, 1);
        @(negedge clk); chk_outs("wd_unfrozen", 1, 0, 0, 0);
        tick();

        // Asynchronous reset in HOLD clears everything; no leftover stall afterwards.
        drive(mk(2, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); chk_outs("rh_c1", 0, 1, 0, 0);
        tick();
        set_idle();
        chk("rh/stall_before", bus.stall_cycles, 3);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("rh_async", 0, 0, 0, 1);
        chk("rh/stall_cycles", bus.stall_cycles, 0);
        chk("rh/flush_count",  bus.flush_count,  0);
        chk("rh/mem_timeout",  bus.mem_timeout,  0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        @(negedge clk); chk_outs("rh_after", 1, 0, 0, 0);
        tick();
        chk("rh/stall_after", bus.stall_cycles, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
